// File: rtl/sha3_pkg.sv
// Shared constants, FSM states and lane tagging for the SHA3-256 rate padder.
// Pure declarations; no logic of its own.
package sha3_pkg;

  localparam int         RATE_BYTES = 136;
  localparam int         RATE_LANES = RATE_BYTES / 8;
  localparam logic [7:0] PAD_DS     = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef enum logic [1:0] {ABSORB, EMIT, PAD} state_t;

  typedef struct packed {
    logic [4:0] idx;
    logic       blk_end;
    logic       is_final;
  } lane_tag_t;

  // First lane holding no message data yet: ceil(cnt / 8).
  function automatic logic [4:0] next_lane_idx(input logic [7:0] cnt);
    return cnt[7:3] + {4'd0, |cnt[2:0]};
  endfunction

endpackage

// File: rtl/ppa_sk_i8_o8.sv
// 8-bit Sklansky parallel-prefix adder, carry-in 0, carry-out dropped.
// Combinational, three prefix levels.
module ppa_sk_i8_o8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    // Level 1: odd bits absorb their even neighbour.
    g1 = g0 | (p0 & {g0[6], 1'b0, g0[4], 1'b0, g0[2], 1'b0, g0[0], 1'b0});
    p1 = p0 & {p0[6], 1'b1, p0[4], 1'b1, p0[2], 1'b1, p0[0], 1'b1};
    g2 = g1 | (p1 & {g1[5], g1[5], 2'b00, g1[1], g1[1], 2'b00});
    p2 = p1 & {p1[5], p1[5], 2'b11, p1[1], p1[1], 2'b11};
    g3 = g2 | (p2 & {{4{g2[3]}}, 4'b0000});
    sum = p0 ^ {g3[6:0], 1'b0};
  end

endmodule

// File: rtl/sha3_rate_padder.sv
// Packs message bytes into 64-bit lanes with SHA3 0x06..0x80 padding; lane valid the cycle after it completes.
// in_ready drops while a lane waits on out_ready, so bytes stall upstream rather than being dropped.
module sha3_rate_padder #(
  parameter int RATE_BYTES = sha3_pkg::RATE_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_nobyte,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_lane,
  output logic [4:0]  out_idx,
  output logic        out_blk_end,
  output logic        out_final,
  input  logic        out_ready
);

  import sha3_pkg::*;

  localparam logic [7:0] RATE_END = 8'(RATE_BYTES);
  localparam logic [4:0] LAST_IDX = 5'(RATE_BYTES / 8 - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_step, cnt_sum, cnt_inc;
  logic [63:0] lane, lane_nxt;
  logic        pad_pend, pad_pend_nxt, pad_done, pad_done_nxt;
  lane_tag_t   tag, tag_nxt;
  logic [2:0]  off;
  logic [4:0]  cur_idx, pad_idx;

  assign cnt_step = (state == PAD) ? 8'd8 : 8'd1;

  ppa_sk_i8_o8 u_cnt_add (
    .a   (cnt),
    .b   (cnt_step),
    .sum (cnt_sum)
  );

  assign cnt_inc = (cnt_sum == RATE_END) ? 8'd0 : cnt_sum;
  assign off     = cnt[2:0];
  assign cur_idx = cnt[7:3];
  // After a short last lane cnt sits mid-lane, so padding lanes round up.
  assign pad_idx = next_lane_idx(cnt);

  assign in_ready    = (state == ABSORB);
  assign out_valid   = (state == EMIT);
  assign out_lane    = lane;
  assign out_idx     = tag.idx;
  assign out_blk_end = tag.blk_end;
  assign out_final   = tag.is_final;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lane_nxt     = lane;
    pad_pend_nxt = pad_pend;
    pad_done_nxt = pad_done;
    tag_nxt      = tag;
    unique case (state)
      ABSORB: begin
        if (in_valid) begin
          cnt_nxt = cnt_inc;
          lane_nxt[{off, 3'b000} +: 8] = in_nobyte ? PAD_DS : in_data;
          if (in_last && !in_nobyte && off == 3'd7) begin
            pad_pend_nxt = 1'b1;
          end else if (in_last) begin
            if (!in_nobyte) lane_nxt[{off + 3'd1, 3'b000} +: 8] = PAD_DS;
            if (cur_idx == LAST_IDX) lane_nxt[63:56] = lane_nxt[63:56] ^ PAD_END;
            pad_done_nxt = 1'b1;
          end
          if (in_last || off == 3'd7) begin
            state_nxt = EMIT;
            tag_nxt   = '{idx: cur_idx, blk_end: cur_idx == LAST_IDX,
                          is_final: (cur_idx == LAST_IDX) && pad_done_nxt};
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          lane_nxt = '0;
          tag_nxt  = '0;
          if (tag.is_final) begin
            cnt_nxt      = '0;
            pad_pend_nxt = 1'b0;
            pad_done_nxt = 1'b0;
            state_nxt    = ABSORB;
          end else if (pad_pend || pad_done) begin
            state_nxt = PAD;
          end else begin
            state_nxt = ABSORB;
          end
        end
      end
      PAD: begin
        lane_nxt = '0;
        if (pad_pend) begin
          lane_nxt[7:0] = PAD_DS;
          pad_pend_nxt  = 1'b0;
          pad_done_nxt  = 1'b1;
        end
        if (pad_idx == LAST_IDX) lane_nxt[63:56] = lane_nxt[63:56] ^ PAD_END;
        cnt_nxt   = cnt_inc;
        tag_nxt   = '{idx: pad_idx, blk_end: pad_idx == LAST_IDX,
                      is_final: (pad_idx == LAST_IDX) && pad_done_nxt};
        state_nxt = EMIT;
      end
      default: state_nxt = ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ABSORB;
      cnt      <= '0;
      lane     <= '0;
      pad_pend <= 1'b0;
      pad_done <= 1'b0;
      tag      <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lane     <= lane_nxt;
      pad_pend <= pad_pend_nxt;
      pad_done <= pad_done_nxt;
      tag      <= tag_nxt;
    end
  end

endmodule

// File: tb/tb_sha3_rate_padder.sv
// Bench for sha3_rate_padder: random and directed messages scored against a padded-byte-array model.
module tb_sha3_rate_padder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_last, in_nobyte, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_blk_end, out_final, out_ready;
  logic [63:0] out_lane;
  logic [4:0]  out_idx;

  always #5 clk = ~clk;

  sha3_rate_padder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nobyte   (in_nobyte),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_lane    (out_lane),
    .out_idx     (out_idx),
    .out_blk_end (out_blk_end),
    .out_final   (out_final),
    .out_ready   (out_ready)
  );

  int total = 0;
  int bad   = 0;

  byte unsigned msg[$];
  logic [70:0]  exp_w[$];   // {final, blk_end, idx, lane}
  logic [70:0]  got_w[$];
  logic [63:0]  st_lane[$];
  logic [4:0]   st_idx[$];
  logic         st_rdy[$];
  logic         extra_vld;

  // Reference: append 0x06, zero-fill to a whole number of blocks, XOR 0x80 into the last byte.
  task automatic build_expected();
    byte unsigned p[$];
    int nblk;
    logic [63:0] w;
    p = msg;
    nblk = msg.size() / 136 + 1;
    while (p.size() < nblk * 136) p.push_back(8'h00);
    p[msg.size()] = p[msg.size()] ^ 8'h06;
    p[nblk * 136 - 1] = p[nblk * 136 - 1] ^ 8'h80;
    exp_w.delete();
    for (int l = 0; l < nblk * 17; l++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w = w | (64'(p[8 * l + k]) << (8 * k));
      exp_w.push_back({1'(l == nblk * 17 - 1), 1'(l % 17 == 16), 5'(l % 17), w});
    end
  endtask

  task automatic run_msg(input bit nobyte, input bit rnd, input int bp_at);
    int n, si, sc, rc, stall_n;
    n = msg.size();
    si = 0; sc = 0; rc = 0; stall_n = 0;
    build_expected();
    got_w.delete(); st_lane.delete(); st_idx.delete(); st_rdy.delete();
    fork
      begin
        while (si < (nobyte ? 1 : n) && sc < 3000) begin
          @(negedge clk);
          sc++;
          if (rnd && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
          end else begin
            in_valid  = 1'b1;
            in_nobyte = nobyte;
            in_data   = nobyte ? 8'($urandom) : msg[si];
            in_last   = nobyte || (si == n - 1);
            if (in_ready) si++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_nobyte = 1'b0;
      end
      begin
        while (got_w.size() < exp_w.size() && rc < 3000) begin
          @(negedge clk);
          rc++;
          out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (bp_at >= 0 && stall_n < 5 && out_valid && got_w.size() == bp_at) begin
            out_ready = 1'b0;
            st_lane.push_back(out_lane);
            st_idx.push_back(out_idx);
            st_rdy.push_back(in_ready);
            stall_n++;
          end
          if (out_valid && out_ready) got_w.push_back({out_final, out_blk_end, out_idx, out_lane});
        end
      end
    join
    out_ready = 1'b1;
    extra_vld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra_vld = 1'b1;
    end
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = 0; in_last = 0; in_nobyte = 0; out_ready = 1;
    #3 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_lane !== 64'h0) begin bad++; $display("FAIL reset_out_lane got=%h want=0", out_lane); end
    total++; if (out_idx !== 5'd0) begin bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    total++; if ({out_blk_end, out_final} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {out_blk_end, out_final}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty();
    msg.delete();
    run_msg(1'b1, 1'b0, -1);
    total++; if (got_w.size() != 17) begin bad++; $display("FAIL empty_count got=%0d want=17", got_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL empty_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
    if (got_w.size() == 17) begin
      total++; if (got_w[0][63:0] !== 64'h6) begin bad++; $display("FAIL empty_lane0 got=%h want=6", got_w[0][63:0]); end
      total++; if (got_w[16] !== {2'b11, 5'd16, 64'h8000_0000_0000_0000}) begin bad++; $display("FAIL empty_lane16 got=%h", got_w[16]); end
    end
    total++; if (extra_vld !== 1'b0) begin bad++; $display("FAIL empty_extra got=%b want=0", extra_vld); end
  endtask

  task automatic test_abc();
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0, -1);
    total++; if (got_w.size() != 17) begin bad++; $display("FAIL abc_count got=%0d want=17", got_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL abc_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
    if (got_w.size() > 0) begin
      total++; if (got_w[0][63:0] !== 64'h0000_0000_0663_6261) begin bad++; $display("FAIL abc_lane0 got=%h want=0000000006636261", got_w[0][63:0]); end
    end
  endtask

  task automatic test_len135();
    msg.delete();
    repeat (135) msg.push_back(8'hAA);
    run_msg(1'b0, 1'b1, -1);
    total++; if (got_w.size() != 17) begin bad++; $display("FAIL len135_count got=%0d want=17", got_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL len135_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
    if (got_w.size() == 17) begin
      total++; if (got_w[16] !== {2'b11, 5'd16, 64'h86AA_AAAA_AAAA_AAAA}) begin bad++; $display("FAIL len135_lane16 got=%h", got_w[16]); end
    end
    total++; if (extra_vld !== 1'b0) begin bad++; $display("FAIL len135_extra got=%b want=0", extra_vld); end
  endtask

  task automatic test_len136();
    msg.delete();
    repeat (136) msg.push_back(8'hAA);
    run_msg(1'b0, 1'b0, -1);
    total++; if (got_w.size() != 34) begin bad++; $display("FAIL len136_count got=%0d want=34", got_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL len136_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
    if (got_w.size() == 34) begin
      total++; if (got_w[16] !== {2'b01, 5'd16, 64'hAAAA_AAAA_AAAA_AAAA}) begin bad++; $display("FAIL len136_blk1_end got=%h", got_w[16]); end
      total++; if (got_w[17][63:0] !== 64'h6) begin bad++; $display("FAIL len136_blk2_lane0 got=%h want=6", got_w[17][63:0]); end
      total++; if (got_w[33] !== {2'b11, 5'd16, 64'h8000_0000_0000_0000}) begin bad++; $display("FAIL len136_blk2_end got=%h", got_w[33]); end
    end
  endtask

  task automatic test_backpressure();
    msg.delete();
    repeat (40) msg.push_back(8'($urandom));
    run_msg(1'b0, 1'b0, 1);
    total++; if (st_lane.size() != 5) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=5", st_lane.size()); end
    for (int k = 0; k < st_lane.size(); k++) begin
      total++; if (st_lane[k] !== exp_w[1][63:0]) begin bad++; $display("FAIL bp_lane_hold c%0d got=%h want=%h", k, st_lane[k], exp_w[1][63:0]); end
      total++; if (st_idx[k] !== 5'd1) begin bad++; $display("FAIL bp_idx_hold c%0d got=%0d want=1", k, st_idx[k]); end
      total++; if (st_rdy[k] !== 1'b0) begin bad++; $display("FAIL bp_in_ready c%0d got=%b want=0", k, st_rdy[k]); end
    end
    total++; if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL bp_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int si, sc;
    si = 0; sc = 0;
    out_ready = 1'b1;
    while (si < 20 && sc < 300) begin
      @(negedge clk);
      sc++;
      in_valid = 1'b1; in_last = 1'b0; in_nobyte = 1'b0;
      in_data = 8'(8'h11 + si);
      if (in_ready) si++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (out_lane !== 64'h0) begin bad++; $display("FAIL rstmid_out_lane got=%h want=0", out_lane); end
    total++; if ({out_idx, out_blk_end, out_final} !== 7'd0) begin bad++; $display("FAIL rstmid_tag got=%b want=0", {out_idx, out_blk_end, out_final}); end
    @(negedge clk);
    rst_n = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(1'b0, 1'b0, -1);
    total++; if (got_w.size() != 17) begin bad++; $display("FAIL rstmid_abc_count got=%0d want=17", got_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL rstmid_abc_lane%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_random();
    int lens[8];
    lens = '{8, 128, 0, 271, 272, 0, 0, 0};
    for (int t = 5; t < 8; t++) lens[t] = $urandom_range(1, 300);
    for (int t = 0; t < 8; t++) begin
      msg.delete();
      for (int b = 0; b < lens[t]; b++) msg.push_back(8'($urandom));
      run_msg(lens[t] == 0, 1'b1, -1);
      total++; if (got_w.size() != exp_w.size()) begin bad++; $display("FAIL rand%0d_count len=%0d got=%0d want=%0d", t, lens[t], got_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL rand%0d_lane%0d len=%0d got=%h want=%h", t, i, lens[t], got_w[i], exp_w[i]); end
      end
      total++; if (extra_vld !== 1'b0) begin bad++; $display("FAIL rand%0d_extra got=%b want=0", t, extra_vld); end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_len135();
    test_len136();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha3_rate_padder.md
# sha3_rate_padder

- Byte-serial front end of the SHA3-256 hash path. It accepts message bytes over a valid/ready handshake and packs them little-endian into 64-bit lanes.
- It applies SHA3 domain padding (0x06 … 0x80) and presents lanes of 136-byte rate blocks (17 lanes) to the Keccak absorb stage.
- The rate-position counter advances through the team's 8-bit Sklansky prefix adder, `ppa_sk_i8_o8`.

## Interface
Parameters:
- RATE_BYTES, 136, rate in bytes; must be a multiple of 8 and ≤ 248.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input byte beat valid.
- in_data  in  8  message byte.
- in_last  in  1  beat is the final beat of the message.
- in_nobyte  in  1  beat carries no byte. Legal only with in_last=1, for a zero-length message.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_valid  out  1  lane valid.
- out_lane  out  64  lane; byte k occupies bits [8k+7:8k].
- out_idx  out  5  lane index within block, 0..16.
- out_blk_end  out  1  high with lane 16 of every block.
- out_final  out  1  high with lane 16 of the final block only.
- out_ready  in  1  downstream accepts lane.

## Operation
- State `ABSORB`: in_ready=1. An accepted byte is written at cnt[2:0] of the lane register, and cnt advances by 1.
  - Lane completes when cnt[2:0]==7 → go to `EMIT`.
  - Accepted beat with in_last=1:
    - If offset<7, byte offset+1 gets 0x06 and the higher bytes are zero.
    - If lane index==16, byte 7 is additionally XORed with 0x80.
    - Set pad_done=1 and go to `EMIT`.
    - If offset==7, set pad_pend=1 instead (0x06 goes into the next lane).
  - Zero-length message (in_nobyte=1): lane = 0x06 at byte 0, pad_done=1, go to `EMIT`.
- State `EMIT`: out_valid=1 and lane outputs held stable. On out_ready:
  - Lane 16 with pad_done: out_final=1. Clear cnt, pad_done and lane; go to `ABSORB`.
  - pad_pend or pad_done: go to `PAD`.
  - Otherwise: go to `ABSORB`.
- State `PAD`: build the whole lane in one cycle.
  - Byte 0 = 0x06 if pad_pend (then clear pad_pend, set pad_done). All other bytes zero.
  - Byte 7 ^= 0x80 when lane index==16.
  - cnt advances by 8. Go to `EMIT`.
- cnt is 8-bit and always equals the byte position in the block. Next value = `ppa_sk_i8_o8(cnt, step)` with step ∈ {1, 8}. A sum of RATE_BYTES wraps to 0; out_idx = cnt[7:3] of the emitted lane.
- Lane register clears after each lane handshake.
- in_valid while in_ready=0 is ignored; upstream holds the beat.
- Reset (any time, including mid-block): state `ABSORB`, cnt=0, lane=0, pad_pend=pad_done=0. The partial message is discarded.

## Timing
- Reset values: in_ready=1; out_valid, out_lane, out_idx, out_blk_end, out_final all 0.
- All outputs are registered. The lane completed by an accept at edge N is valid after edge N; earliest handshake is edge N+1.
- Peak throughput: 8 bytes per 9 cycles with out_ready tied high.
- Padding lanes take 2 cycles each (`PAD` then `EMIT`).
- Last byte at position 134: single pad byte 0x86 at byte 7 of lane 16.
- Last byte at position 135: the block closes unpadded with out_final=0. A new block follows: lane 0 = 0x06, lanes 1–15 zero, lane 16 = 0x80<<56, out_final=1.
- The next message's first byte may be accepted the cycle after the final handshake.

## Structure
- Package `sha3_pkg`: RATE_BYTES, RATE_LANES (17), PAD_DS (8'h06), PAD_END (8'h80), state enum {ABSORB, EMIT, PAD}.
- Sub-module: `ppa_sk_i8_o8` instantiated once for the counter increment. No other hierarchy.

## Test plan
- Empty message (in_nobyte=1, in_last=1) → 17 lanes:
  - lane0 = 64'h0000_0000_0000_0006.
  - lanes 1–15 = 0.
  - lane16 = 64'h8000_0000_0000_0000 with out_blk_end=out_final=1.
- "abc" (0x61,0x62,0x63, last on 0x63) → lane0 = 64'h0000_0000_0663_6261; lanes 1–15 = 0; lane16 = 64'h8000…0000, final.
- 135 bytes of 0xAA → lane16 = 64'h86AA_AAAA_AAAA_AAAA, out_final=1, exactly 17 lanes.
- 136 bytes of 0xAA → 34 lanes total:
  - Block 1: lane16 = all 0xAA with out_final=0.
  - Block 2: lane0 = 64'h06, lane16 = 64'h8000…0000 with out_final=1.
- Backpressure: out_ready low for 5 cycles mid-message → out_lane/out_idx stable and in_ready=0 throughout; no byte lost or duplicated.
- rst_n pulsed low after 20 bytes → outputs at reset values immediately. A following "abc" message yields the "abc" lanes above.
